// File: rtl/frost32_mem_ctrl_pkg.sv
// Shared types for the Frost32 memory controller: CPU access enums,
// controller states and byte-count helpers.
package frost32_mem_ctrl_pkg;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } data_inout_access_type_t;

    typedef enum logic [1:0] {
        Dias8  = 2'd0,
        Dias16 = 2'd1,
        Dias32 = 2'd2
    } data_inout_access_size_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StXfer  = 2'd1,
        StDrain = 2'd2,
        StAck   = 2'd3
    } mem_ctrl_state_t;

    // Size code 3 has no name and is handled as a full word.
    function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
        unique case (size)
            Dias8:   bytes_for_size = 3'd1;
            Dias16:  bytes_for_size = 3'd2;
            default: bytes_for_size = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] mask_bytes(input logic [31:0] v,
                                               input logic [2:0]  n);
        unique case (n)
            3'd1:    mask_bytes = {24'd0, v[7:0]};
            3'd2:    mask_bytes = {16'd0, v[15:0]};
            default: mask_bytes = v;
        endcase
    endfunction

endpackage

// File: rtl/frost32_mem_ctrl.sv
// Serialises Frost32 8/16/32-bit requests into big-endian byte
// accesses on a byte-wide synchronous RAM.
module frost32_mem_ctrl
    import frost32_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_access_type,
    input  logic [1:0]            cpu_access_size,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wr_data,
    output logic [31:0]           cpu_rd_data,
    output logic                  cpu_busy,
    output logic                  cpu_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rd_data
);

    mem_ctrl_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    data_inout_access_type_t type_q;
    logic [2:0]              n_q;
    logic [2:0]              k_q;
    logic [31:0]             wdata_q;
    logic [31:0]             accum_q;
    logic                    re_d_q;
    logic [31:0]             rd_q;
    logic [1:0]              byte_idx;
    logic                    last_byte;

    assign cpu_rd_data = rd_q;
    // Byte k of an N-byte big-endian value sits at bit 8*(N-1-k).
    assign byte_idx    = 2'(n_q - 3'd1 - k_q);
    assign last_byte   = (k_q == n_q - 3'd1);

    always_comb begin
        state_d     = state_q;
        cpu_busy    = 1'b0;
        cpu_ack     = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) state_d = StXfer;
            end
            StXfer: begin
                cpu_busy = 1'b1;
                mem_addr = base_q + ADDR_WIDTH'(k_q);
                if (type_q == DiatWrite) begin
                    mem_we      = 1'b1;
                    mem_wr_data = 8'(wdata_q >> {byte_idx, 3'b000});
                end else begin
                    mem_re = 1'b1;
                end
                if (last_byte)
                    state_d = (type_q == DiatWrite) ? StAck : StDrain;
            end
            StDrain: begin
                cpu_busy = 1'b1;
                state_d  = StAck;
            end
            StAck: begin
                cpu_ack = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            type_q  <= DiatRead;
            n_q     <= 3'd0;
            k_q     <= 3'd0;
            wdata_q <= '0;
            accum_q <= '0;
            re_d_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            re_d_q  <= mem_re;
            if (re_d_q)
                accum_q <= {accum_q[23:0], mem_rd_data};
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        base_q  <= cpu_addr[ADDR_WIDTH-1:0];
                        type_q  <= data_inout_access_type_t'(cpu_access_type);
                        n_q     <= bytes_for_size(cpu_access_size);
                        wdata_q <= cpu_wr_data;
                        k_q     <= 3'd0;
                        accum_q <= '0;
                    end
                end
                StXfer:  k_q <= k_q + 3'd1;
                // Last read byte arrives in this cycle; fold it in directly.
                StDrain: rd_q <= mask_bytes({accum_q[23:0], mem_rd_data}, n_q);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_mem_ctrl.sv
// Scoreboard bench for frost32_mem_ctrl with a byte-wide synchronous
// RAM model.
module tb_frost32_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_access_type;
    logic [1:0]  cpu_access_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rd_data;

    logic [7:0]  ram [65536];
    int          errors = 0;
    int          checks = 0;
    int          we_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    frost32_mem_ctrl #(.ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (cpu_req),
        .cpu_access_type (cpu_access_type),
        .cpu_access_size (cpu_access_size),
        .cpu_addr        (cpu_addr),
        .cpu_wr_data     (cpu_wr_data),
        .cpu_rd_data     (cpu_rd_data),
        .cpu_busy        (cpu_busy),
        .cpu_ack         (cpu_ack),
        .mem_addr        (mem_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .mem_rd_data     (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wr_data;
        if (mem_re) mem_rd_data <= ram[mem_addr];
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run_xfer(input string tag, input bit wr,
                            input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp,
                            input int lat, input bit scramble,
                            input bit hold);
        exp_t e;
        int   cyc;
        bit   done;
        e.tag  = tag;
        e.data = exp;
        e.lat  = lat;
        sb.push_back(e);
        we_cnt          = 0;
        cpu_req         = 1'b1;
        cpu_access_type = wr;
        cpu_access_size = sz;
        cpu_addr        = addr;
        cpu_wr_data     = wd;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && cyc == 1) begin
                cpu_addr        = ~addr;
                cpu_wr_data     = ~wd;
                cpu_access_type = ~wr;
                cpu_access_size = 2'd0;
            end
            if (cpu_ack) begin
                done = 1'b1;
                e = sb.pop_front();
                chk({e.tag, "_data"}, cpu_rd_data, e.data);
                chk({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
                if (!hold) cpu_req = 1'b0;
            end else begin
                chk({tag, "_busy"}, {31'd0, cpu_busy}, 32'd1);
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"},  {31'd0, cpu_ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, cpu_busy}, 32'd0);
        chk({tag, "_we"},   {31'd0, mem_we}, 32'd0);
        chk({tag, "_re"},   {31'd0, mem_re}, 32'd0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_wrd"},  {24'd0, mem_wr_data}, 32'd0);
        chk({tag, "_rd"},   cpu_rd_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        rst_n           = 1'b0;
        cpu_req         = 1'b0;
        cpu_access_type = 1'b0;
        cpu_access_size = 2'd0;
        cpu_addr        = 32'd0;
        cpu_wr_data     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("rst0");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_xfer("w32", 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF,
                 last_rd, 5, 1'b0, 1'b0);
        chk("w32_we_cnt", 32'(we_cnt), 32'd4);
        chk("w32_ram", {ram[16'h100], ram[16'h101], ram[16'h102],
                        ram[16'h103]}, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        run_xfer("r32", 1'b0, 2'd2, 32'h0000_0100, 32'd0,
                 32'hDEAD_BEEF, 6, 1'b0, 1'b0);
        chk("r32_we_cnt", 32'(we_cnt), 32'd0);
        @(posedge clk);
        #1;
        run_xfer("r16", 1'b0, 2'd1, 32'h0000_0102, 32'd0,
                 32'h0000_BEEF, 4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        run_xfer("r8", 1'b0, 2'd0, 32'h0000_0101, 32'd0,
                 32'h0000_00AD, 3, 1'b0, 1'b0);
        last_rd = 32'h0000_00AD;
        @(posedge clk);
        #1;

        // Reset in the middle of a 32-bit read.
        cpu_req         = 1'b1;
        cpu_access_type = 1'b0;
        cpu_access_size = 2'd2;
        cpu_addr        = 32'h0000_0100;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mrst_no_ack", {31'd0, cpu_ack}, 32'd0);
        end
        chk_idle_outputs("mrst");
        rst_n   = 1'b1;
        last_rd = 32'd0;
        @(posedge clk);
        #1;
        chk("mrst_after_ack", {31'd0, cpu_ack}, 32'd0);

        run_xfer("wwrap", 1'b1, 2'd1, 32'h0000_FFFF, 32'h0000_1234,
                 last_rd, 3, 1'b0, 1'b0);
        chk("wwrap_ram", {16'd0, ram[16'hFFFF], ram[16'h0000]},
            32'h0000_1234);
        @(posedge clk);
        #1;
        run_xfer("rwrap", 1'b0, 2'd1, 32'h8000_FFFF, 32'd0,
                 32'h0000_1234, 4, 1'b0, 1'b0);
        last_rd = 32'h0000_1234;
        @(posedge clk);
        #1;

        // Inputs scrambled after accept; request held through Ack.
        run_xfer("hs", 1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344,
                 last_rd, 5, 1'b1, 1'b1);
        cpu_access_type = 1'b1;
        cpu_access_size = 2'd0;
        cpu_addr        = 32'h0000_0400;
        cpu_wr_data     = 32'h0000_0055;
        @(posedge clk);
        #1;
        chk("hs_idle_busy", {31'd0, cpu_busy}, 32'd0);
        chk("hs_idle_ack",  {31'd0, cpu_ack}, 32'd0);
        run_xfer("b2b", 1'b1, 2'd0, 32'h0000_0400, 32'h0000_0055,
                 last_rd, 2, 1'b0, 1'b0);
        chk("hs_ram", {ram[16'h300], ram[16'h301], ram[16'h302],
                       ram[16'h303]}, 32'h1122_3344);
        chk("b2b_ram", {24'd0, ram[16'h400]}, 32'h0000_0055);
        chk("b2b_we_cnt", 32'(we_cnt), 32'd1);
        @(posedge clk);
        #1;

        run_xfer("w3", 1'b1, 2'd3, 32'h0000_0200, 32'hA1B2_C3D4,
                 last_rd, 5, 1'b0, 1'b0);
        chk("w3_ram", {ram[16'h200], ram[16'h201], ram[16'h202],
                       ram[16'h203]}, 32'hA1B2_C3D4);
        chk("w3_we_cnt", 32'(we_cnt), 32'd4);
        @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
